// File: rtl/usr_pkg.sv
// Shared types and the single-step shift function for usr_shift_reg.
// The rotate paths exist only when USR_ROTATE_EN is defined.
package usr_pkg;

  localparam int MAX_W = 64;
  localparam int IDX_W = $clog2(MAX_W);

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    LOAD = 3'd1,
    SHR  = 3'd2,
    SHL  = 3'd3,
    ROTR = 3'd4,
    ROTL = 3'd5
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Modes that enter RUN; rotates count only when they are built.
  function automatic logic is_shift(input mode_t m);
    logic r;
    case (m)
      SHR, SHL: r = 1'b1;
`ifdef USR_ROTATE_EN
      ROTR, ROTL: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Operates on a zero-extended register; msb is the index of the real top bit.
  function automatic logic [MAX_W-1:0] next_q(input mode_t mode,
                                              input logic [MAX_W-1:0] q,
                                              input logic serial_in,
                                              input logic [IDX_W-1:0] msb);
    logic [MAX_W-1:0] r;
    logic [MAX_W-1:0] mask;
    mask = ~(({MAX_W{1'b1}} << msb) << 1);
    r = q;
    case (mode)
      SHR: begin
        r = q >> 1;
        r[msb] = serial_in;
      end
      SHL: r = ((q << 1) | {{(MAX_W-1){1'b0}}, serial_in}) & mask;
`ifdef USR_ROTATE_EN
      ROTR: begin
        r = q >> 1;
        r[msb] = q[0];
      end
      ROTL: r = ((q << 1) | {{(MAX_W-1){1'b0}}, q[msb]}) & mask;
`endif
      default: r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/usr_shift_reg.sv
// Universal shift register: parallel load plus multi-step shift with busy/done.
// Define USR_ROTATE_EN to build ROTR/ROTL; otherwise those codes complete as no-ops.
//
// Handshake: start is a strobe honoured only in IDLE (busy=0); done is a
// one-cycle pulse on the edge that writes the final q. Nothing is queued.
module usr_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic             start,
  input  mode_t            mode,
  input  logic [CNT_W-1:0] count,
  input  logic             en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done,
  output state_t           state
);

  localparam logic [IDX_W-1:0] MSB = IDX_W'(WIDTH - 1);

  mode_t            mode_r, mode_n;
  state_t           state_n;
  logic [CNT_W-1:0] rem, rem_n, count_c;
  logic [WIDTH-1:0] q_n;
  logic             busy_n, done_n;
  logic [MAX_W-1:0] q_ext;

  assign count_c = (count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : count;

  always_comb begin
    q_ext = '0;
    q_ext[WIDTH-1:0] = q;
  end

  always_comb begin
    state_n = state;
    q_n     = q;
    rem_n   = rem;
    busy_n  = busy;
    done_n  = 1'b0;
    mode_n  = mode_r;
    case (state)
      IDLE: begin
        if (start) begin
          if (mode == LOAD) begin
            q_n    = load_data;
            done_n = 1'b1;
          end else if (is_shift(mode) && (count_c != '0)) begin
            mode_n  = mode;
            rem_n   = count_c;
            busy_n  = 1'b1;
            state_n = RUN;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (en) begin
          q_n   = WIDTH'(next_q(mode_r, q_ext, serial_in, MSB));
          rem_n = rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      q      <= '0;
      rem    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      mode_r <= HOLD;
    end else begin
      state  <= state_n;
      q      <= q_n;
      rem    <= rem_n;
      busy   <= busy_n;
      done   <= done_n;
      mode_r <= mode_n;
    end
  end

  // Serial tap follows the last latched shift direction, not the live mode input.
  always_comb begin
    case (mode_r)
      SHL, ROTL: serial_out = q[WIDTH-1];
      default:   serial_out = q[0];
    endcase
  end

endmodule

// File: tb/tb_usr_shift_reg.sv
// Directed bench for usr_shift_reg (WIDTH=8): every done pulse is matched
// against a queue of expected final q values; cycle detail is checked inline.
module tb_usr_shift_reg;
  import usr_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk_2 = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  mode_t            mode = HOLD;
  logic [CNT_W-1:0] count = '0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic             serial_in = 1'b0;
  logic [WIDTH-1:0] q;
  logic             serial_out, busy, done;
  state_t           state;

  logic [WIDTH-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  usr_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk_2(clk_2), .reset_n(reset_n), .start(start), .mode(mode),
    .count(count), .en(en), .load_data(load_data), .serial_in(serial_in),
    .q(q), .serial_out(serial_out), .busy(busy), .done(done), .state(state)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one start strobe; returns at the negedge after the start edge.
  task automatic issue(input mode_t m, input int c, input logic [WIDTH-1:0] d, input logic s);
    @(negedge clk_2);
    start = 1'b1;
    mode = m;
    count = CNT_W'(c);
    load_data = d;
    serial_in = s;
    @(negedge clk_2);
    start = 1'b0;
  endtask

  always @(posedge clk_2) begin
    #1;
    if (done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: q=0x%0h with nothing expected", q);
      end else begin
        check("done_q", 32'(q), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk_2);
    check("rst_q", 32'(q), 32'h00);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_state", 32'(state), 32'(IDLE));
    reset_n = 1'b1;

    // Async reset during a done pulse clears everything without an edge.
    exp_q.push_back(8'hFF);
    issue(LOAD, 0, 8'hFF, 1'b0);
    check("pre_rst_q", 32'(q), 32'hFF);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_q", 32'(q), 32'h00);
    check("async_rst_done", 32'(done), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    @(negedge clk_2);
    reset_n = 1'b1;

    // LOAD
    exp_q.push_back(8'hA5);
    issue(LOAD, 0, 8'hA5, 1'b0);
    check("load_q", 32'(q), 32'hA5);
    check("load_done", 32'(done), 32'h1);
    check("load_busy", 32'(busy), 32'h0);
    @(negedge clk_2);
    check("load_done_1cyc", 32'(done), 32'h0);

    // SHR by 3 with fill 1
    en = 1'b1;
    exp_q.push_back(8'hF4);
    issue(SHR, 3, 8'h00, 1'b1);
    check("shr_start_busy", 32'(busy), 32'h1);
    check("shr_start_q", 32'(q), 32'hA5);
    @(negedge clk_2);
    check("shr_s1", 32'(q), 32'hD2);
    check("shr_s1_busy", 32'(busy), 32'h1);
    @(negedge clk_2);
    check("shr_s2", 32'(q), 32'hE9);
    @(negedge clk_2);
    check("shr_s3", 32'(q), 32'hF4);
    check("shr_done", 32'(done), 32'h1);
    check("shr_busy_end", 32'(busy), 32'h0);
    check("shr_serial_out", 32'(serial_out), 32'h0);

    // Latched mode is still SHR, so serial_out taps bit 0
    exp_q.push_back(8'h81);
    issue(LOAD, 0, 8'h81, 1'b0);
    check("load81_serial_out", 32'(serial_out), 32'h1);

    // SHL by 2 with en gated 1,0,1 and a start pulse while busy
    exp_q.push_back(8'h04);
    issue(SHL, 2, 8'h00, 1'b0);
    check("shl_busy", 32'(busy), 32'h1);
    en = 1'b1;
    @(negedge clk_2);
    check("shl_s1", 32'(q), 32'h02);
    en = 1'b0;
    start = 1'b1;
    mode = LOAD;
    load_data = 8'hFF;
    @(negedge clk_2);
    check("shl_hold_q", 32'(q), 32'h02);
    check("shl_hold_busy", 32'(busy), 32'h1);
    check("shl_hold_done", 32'(done), 32'h0);
    start = 1'b0;
    en = 1'b1;
    @(negedge clk_2);
    check("shl_s2", 32'(q), 32'h04);
    check("shl_done", 32'(done), 32'h1);
    check("shl_serial_out", 32'(serial_out), 32'h0);

    // ROTL by a full width
    exp_q.push_back(8'h3C);
    issue(LOAD, 0, 8'h3C, 1'b0);
    exp_q.push_back(8'h3C);
    issue(ROTL, 8, 8'h00, 1'b0);
`ifdef USR_ROTATE_EN
    check("rotl_busy", 32'(busy), 32'h1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_2);
      if (i == 1) check("rotl_s1", 32'(q), 32'h78);
      if (i < 8) check("rotl_busy_run", 32'(busy), 32'h1);
    end
    check("rotl_done", 32'(done), 32'h1);
    check("rotl_q", 32'(q), 32'h3C);
`else
    check("rotl_done_now", 32'(done), 32'h1);
    check("rotl_no_busy", 32'(busy), 32'h0);
    check("rotl_q", 32'(q), 32'h3C);
`endif

    // count above WIDTH clamps to WIDTH: SHR fill 0 empties the register
    exp_q.push_back(8'h00);
    issue(SHR, 15, 8'h00, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_2);
      if (i == 1) check("clamp_s1", 32'(q), 32'h1E);
      if (i < 8) check("clamp_busy_run", 32'(busy), 32'h1);
    end
    check("clamp_done", 32'(done), 32'h1);
    check("clamp_q", 32'(q), 32'h00);

    // Illegal mode code completes immediately
    exp_q.push_back(8'hF0);
    issue(LOAD, 0, 8'hF0, 1'b0);
    exp_q.push_back(8'hF0);
    issue(mode_t'(3'd6), 3, 8'h00, 1'b0);
    check("illegal_done", 32'(done), 32'h1);
    check("illegal_busy", 32'(busy), 32'h0);

    // Abort: reset after two of five steps, no done afterwards
    issue(SHR, 5, 8'h00, 1'b0);
    @(negedge clk_2);
    check("abort_s1", 32'(q), 32'h78);
    @(negedge clk_2);
    check("abort_s2", 32'(q), 32'h3C);
    #2 reset_n = 1'b0;
    #1;
    check("abort_q", 32'(q), 32'h00);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_state", 32'(state), 32'(IDLE));
    repeat (2) @(negedge clk_2);
    reset_n = 1'b1;
    exp_q.push_back(8'h00);
    issue(HOLD, 0, 8'h00, 1'b0);
    check("cnt0_done", 32'(done), 32'h1);
    check("cnt0_q", 32'(q), 32'h00);
    check("cnt0_busy", 32'(busy), 32'h0);

    repeat (4) @(negedge clk_2);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
